// File: rtl/rkey_store.sv
// rkey_store: round-key store between the 256-bit key expander and the
// iterative AES decryption datapath. It captures the NR+1 round keys the
// expander streams out and replays them highest round first through a
// valid/ready handshake. A loaded schedule can be replayed any number of times.
//
// Optional build macro RKSTORE_FWD_EN adds the rd_fwd input, which selects an
// ascending readout (slot 0 first) for an encryption datapath.
//
// state   | meaning
// --------+---------------------------------------------------------------
// EMPTY   | no valid schedule held (after reset or a length error)
// LOADING | capturing round keys from the expander
// READY   | complete schedule held, waiting for rd_start
// READING | presenting round keys on rk/rk_vld
module rkey_store #(
    parameter int NR = 14,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] rkey,
    input  logic         rkey_vld,
    input  logic         rkey_last,
    output logic         ld_ok,
    output logic         st_full,
    output logic         ld_err,
    input  logic         rd_start,
`ifdef RKSTORE_FWD_EN
    input  logic         rd_fwd,
`endif
    output logic [0:127] rk,
    output logic         rk_vld,
    input  logic         rk_rdy,
    output logic         rk_first,
    output logic         rk_last
);

    typedef enum logic [1:0] {EMPTY, LOADING, READY, READING} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NR);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    state_t        state, nxt_state;
    logic [AW-1:0] wr_idx, nxt_wr_idx;
    logic [AW-1:0] rd_idx, nxt_rd_idx;
    // Set once slot NR has been written; further writes in the same load are dropped.
    logic          wr_ovf, nxt_wr_ovf;
    logic          fwd_q, nxt_fwd;
    logic          nxt_st_full, nxt_ld_err;
    logic          nxt_rk_vld, nxt_rk_first, nxt_rk_last;
    logic          rk_upd;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic          start_fwd;
    logic [AW-1:0] end_idx;
    logic [AW-1:0] step_idx;

    logic [0:127]  mem [0:NR];

`ifdef RKSTORE_FWD_EN
    assign start_fwd = rd_fwd;
`else
    assign start_fwd = 1'b0;
`endif

    assign ld_ok    = (state != READING);
    assign end_idx  = fwd_q ? LAST_IDX : '0;
    assign step_idx = fwd_q ? (rd_idx + ONE_IDX) : (rd_idx - ONE_IDX);

    // Next-state and control: a load from any non-LOADING state takes priority
    // over everything else (including aborting an active readout).
    always_comb begin
        nxt_state    = state;
        nxt_wr_idx   = wr_idx;
        nxt_wr_ovf   = wr_ovf;
        nxt_rd_idx   = rd_idx;
        nxt_fwd      = fwd_q;
        nxt_st_full  = st_full;
        nxt_ld_err   = ld_err;
        nxt_rk_vld   = rk_vld;
        nxt_rk_first = rk_first;
        nxt_rk_last  = rk_last;
        rk_upd       = 1'b0;
        mem_we       = 1'b0;
        mem_wa       = wr_idx;

        if (rkey_vld && (state != LOADING)) begin
            mem_we       = 1'b1;
            mem_wa       = '0;
            nxt_wr_idx   = ONE_IDX;
            nxt_wr_ovf   = 1'b0;
            nxt_st_full  = 1'b0;
            nxt_ld_err   = 1'b0;
            nxt_rk_vld   = 1'b0;
            nxt_rk_first = 1'b0;
            nxt_rk_last  = 1'b0;
            nxt_state    = LOADING;
            if (rkey_last) begin
                if (LAST_IDX == '0) begin
                    nxt_state   = READY;
                    nxt_st_full = 1'b1;
                end else begin
                    nxt_state  = EMPTY;
                    nxt_ld_err = 1'b1;
                end
            end
        end else begin
            case (state)
                LOADING: begin
                    if (rkey_vld) begin
                        mem_we = !wr_ovf;
                        if (wr_idx == LAST_IDX) begin
                            nxt_wr_ovf = 1'b1;
                        end else begin
                            nxt_wr_idx = wr_idx + ONE_IDX;
                        end
                        if (rkey_last) begin
                            if ((wr_idx == LAST_IDX) && !wr_ovf) begin
                                nxt_state   = READY;
                                nxt_st_full = 1'b1;
                            end else begin
                                nxt_state  = EMPTY;
                                nxt_ld_err = 1'b1;
                            end
                        end
                    end
                end
                READY: begin
                    if (rd_start) begin
                        nxt_fwd      = start_fwd;
                        nxt_rd_idx   = start_fwd ? '0 : LAST_IDX;
                        nxt_rk_vld   = 1'b1;
                        nxt_rk_first = 1'b1;
                        nxt_rk_last  = (LAST_IDX == '0);
                        rk_upd       = 1'b1;
                        nxt_state    = READING;
                    end
                end
                READING: begin
                    if (rk_vld && rk_rdy) begin
                        if (rd_idx == end_idx) begin
                            nxt_rk_vld   = 1'b0;
                            nxt_rk_first = 1'b0;
                            nxt_rk_last  = 1'b0;
                            nxt_state    = READY;
                        end else begin
                            nxt_rd_idx   = step_idx;
                            nxt_rk_first = 1'b0;
                            nxt_rk_last  = (step_idx == end_idx);
                            rk_upd       = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; rk is reloaded only when a new key is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            wr_idx   <= '0;
            wr_ovf   <= 1'b0;
            rd_idx   <= '0;
            fwd_q    <= 1'b0;
            st_full  <= 1'b0;
            ld_err   <= 1'b0;
            rk_vld   <= 1'b0;
            rk_first <= 1'b0;
            rk_last  <= 1'b0;
            rk       <= '0;
        end else begin
            state    <= nxt_state;
            wr_idx   <= nxt_wr_idx;
            wr_ovf   <= nxt_wr_ovf;
            rd_idx   <= nxt_rd_idx;
            fwd_q    <= nxt_fwd;
            st_full  <= nxt_st_full;
            ld_err   <= nxt_ld_err;
            rk_vld   <= nxt_rk_vld;
            rk_first <= nxt_rk_first;
            rk_last  <= nxt_rk_last;
            if (rk_upd) begin
                rk <= mem[nxt_rd_idx];
            end
        end
    end

    // Round-key storage; contents are meaningless until a load completes, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= rkey;
        end
    end

endmodule

// File: tb/tb_rkey_store.sv
// Testbench for rkey_store: builds AES-256 round-key schedules with a small
// software key expander, streams them into the store and checks readouts
// against a queue of expected keys.
module tb_rkey_store;

    logic         clk;
    logic         rst;
    logic [0:127] rkey;
    logic         rkey_vld;
    logic         rkey_last;
    logic         ld_ok;
    logic         st_full;
    logic         ld_err;
    logic         rd_start;
    logic [0:127] rk;
    logic         rk_vld;
    logic         rk_rdy;
    logic         rk_first;
    logic         rk_last;
`ifdef RKSTORE_FWD_EN
    logic         rd_fwd;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [127:0] sched [0:1][0:14];
    logic [129:0] exp_q [$];

    rkey_store #(.NR(14), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rkey      (rkey),
        .rkey_vld  (rkey_vld),
        .rkey_last (rkey_last),
        .ld_ok     (ld_ok),
        .st_full   (st_full),
        .ld_err    (ld_err),
        .rd_start  (rd_start),
`ifdef RKSTORE_FWD_EN
        .rd_fwd    (rd_fwd),
`endif
        .rk        (rk),
        .rk_vld    (rk_vld),
        .rk_rdy    (rk_rdy),
        .rk_first  (rk_first),
        .rk_last   (rk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input int s, input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) sched[s][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Streams keys from..n-1 of schedule s; rkey_last on key last_at; an idle cycle before gap_at.
    task automatic load(input int s, input int from, input int n, input int last_at, input int gap_at);
        for (int i = from; i < n; i++) begin
            if (i == gap_at) begin
                rkey_vld = 1'b0;
                step;
            end
            rkey_vld  = 1'b1;
            rkey      = sched[s][i % 15];
            rkey_last = (i == last_at);
            step;
        end
        rkey_vld  = 1'b0;
        rkey_last = 1'b0;
    endtask

    // Queues the expected reverse readout of schedule s and pulses rd_start.
    task automatic start_read(input int s);
        for (int r = 14; r >= 0; r--) exp_q.push_back({sched[s][r], r == 14, r == 0});
        rk_rdy   = 1'b0;
        rd_start = 1'b1;
        step;
        rd_start = 1'b0;
        total_cnt++;
        if (rk_vld !== 1'b1) $display("FAIL rd_latency: rk_vld=%b expected 1", rk_vld);
        else pass_cnt++;
    endtask

    // Accepts up to max_keys keys; mode 0 holds rk_rdy high, mode 1 uses 1,0,0 repeating.
    task automatic drain(input int mode, input int max_keys, output logic [127:0] last_key);
        int           cyc;
        int           got;
        logic         held_v;
        logic [129:0] held;
        logic [129:0] e;
        cyc      = 0;
        got      = 0;
        held_v   = 1'b0;
        held     = '0;
        last_key = '0;
        while (got < max_keys && cyc < 200) begin
            rk_rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (held_v) begin
                total_cnt++;
                if ({rk, rk_first, rk_last} !== held)
                    $display("FAIL rd_hold: got %h expected %h", {rk, rk_first, rk_last}, held);
                else pass_cnt++;
                held_v = 1'b0;
            end
            if (rk_vld !== 1'b1) break;
            if (rk_rdy) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rd_extra: got key %h with nothing expected", rk);
                end else begin
                    e = exp_q.pop_front();
                    if ({rk, rk_first, rk_last} !== e)
                        $display("FAIL rd_key%0d: got %h expected %h", got, {rk, rk_first, rk_last}, e);
                    else pass_cnt++;
                end
                last_key = rk;
                got++;
            end else begin
                held   = {rk, rk_first, rk_last};
                held_v = 1'b1;
            end
            step;
            cyc++;
        end
        rk_rdy = 1'b0;
        total_cnt++;
        if (got != max_keys) $display("FAIL rd_count: accepted %0d keys expected %0d", got, max_keys);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        rkey      = '0;
        rkey_vld  = 1'b0;
        rkey_last = 1'b0;
        rd_start  = 1'b0;
        rk_rdy    = 1'b0;
`ifdef RKSTORE_FWD_EN
        rd_fwd    = 1'b0;
`endif
        #2 rst = 1'b0;
        #10;
        total_cnt += 7;
        if (st_full !== 1'b0)  $display("FAIL rst_st_full: got %b expected 0", st_full);  else pass_cnt++;
        if (ld_err !== 1'b0)   $display("FAIL rst_ld_err: got %b expected 0", ld_err);    else pass_cnt++;
        if (rk_vld !== 1'b0)   $display("FAIL rst_rk_vld: got %b expected 0", rk_vld);    else pass_cnt++;
        if (rk_first !== 1'b0) $display("FAIL rst_rk_first: got %b expected 0", rk_first); else pass_cnt++;
        if (rk_last !== 1'b0)  $display("FAIL rst_rk_last: got %b expected 0", rk_last);  else pass_cnt++;
        if (rk !== 128'h0)     $display("FAIL rst_rk: got %h expected 0", rk);            else pass_cnt++;
        if (ld_ok !== 1'b1)    $display("FAIL rst_ld_ok: got %b expected 1", ld_ok);      else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        step;
    endtask

    task automatic test_load_basic;
        load(0, 0, 8, -1, -1);
        total_cnt += 2;
        if (st_full !== 1'b0) $display("FAIL ld_mid_st_full: got %b expected 0", st_full); else pass_cnt++;
        if (ld_ok !== 1'b1)   $display("FAIL ld_mid_ld_ok: got %b expected 1", ld_ok);     else pass_cnt++;
        load(0, 8, 15, 14, -1);
        total_cnt += 3;
        if (st_full !== 1'b1) $display("FAIL ld_st_full: got %b expected 1", st_full); else pass_cnt++;
        if (ld_err !== 1'b0)  $display("FAIL ld_ld_err: got %b expected 0", ld_err);   else pass_cnt++;
        if (ld_ok !== 1'b1)   $display("FAIL ld_ld_ok: got %b expected 1", ld_ok);     else pass_cnt++;
    endtask

    task automatic test_read_full;
        logic [127:0] last_key;
        start_read(0);
        total_cnt += 3;
        if (rk !== 128'h24fc79ccbf0979e9371ac23c6d68de36)
            $display("FAIL rd_first_key: got %h expected 24fc79ccbf0979e9371ac23c6d68de36", rk);
        else pass_cnt++;
        if (rk_first !== 1'b1) $display("FAIL rd_first_flag: got %b expected 1", rk_first); else pass_cnt++;
        if (ld_ok !== 1'b0)    $display("FAIL rd_ld_ok: got %b expected 0", ld_ok);         else pass_cnt++;
        drain(0, 15, last_key);
        total_cnt += 3;
        if (last_key !== 128'h000102030405060708090a0b0c0d0e0f)
            $display("FAIL rd_last_key: got %h expected 000102030405060708090a0b0c0d0e0f", last_key);
        else pass_cnt++;
        if (rk_vld !== 1'b0)  $display("FAIL rd_end_vld: got %b expected 0", rk_vld);   else pass_cnt++;
        if (st_full !== 1'b1) $display("FAIL rd_end_full: got %b expected 1", st_full); else pass_cnt++;
    endtask

    task automatic test_read_stall;
        logic [127:0] last_key;
        for (int pass = 0; pass < 2; pass++) begin
            start_read(0);
            drain(1, 15, last_key);
            total_cnt++;
            if (rk_vld !== 1'b0) $display("FAIL stall_end_vld%0d: got %b expected 0", pass, rk_vld);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_vs_read;
        logic [127:0] last_key;
        rkey_vld  = 1'b1;
        rkey      = sched[0][0];
        rd_start  = 1'b1;
        step;
        rd_start  = 1'b0;
        rkey_vld  = 1'b0;
        total_cnt += 2;
        if (rk_vld !== 1'b0)  $display("FAIL coll_rk_vld: got %b expected 0", rk_vld);   else pass_cnt++;
        if (st_full !== 1'b0) $display("FAIL coll_st_full: got %b expected 0", st_full); else pass_cnt++;
        load(0, 1, 15, 14, -1);
        start_read(0);
        drain(0, 15, last_key);
    endtask

    task automatic test_bad_load;
        logic [127:0] last_key;
        load(0, 0, 10, 9, -1);
        total_cnt += 2;
        if (ld_err !== 1'b1)  $display("FAIL bad_ld_err: got %b expected 1", ld_err);   else pass_cnt++;
        if (st_full !== 1'b0) $display("FAIL bad_st_full: got %b expected 0", st_full); else pass_cnt++;
        rd_start = 1'b1;
        step;
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (rk_vld !== 1'b0) $display("FAIL bad_rd_ignored%0d: got %b expected 0", i, rk_vld);
            else pass_cnt++;
            step;
        end
        load(0, 0, 15, 14, 6);
        total_cnt += 2;
        if (ld_err !== 1'b0)  $display("FAIL fix_ld_err: got %b expected 0", ld_err);   else pass_cnt++;
        if (st_full !== 1'b1) $display("FAIL fix_st_full: got %b expected 1", st_full); else pass_cnt++;
        start_read(0);
        drain(0, 15, last_key);
    endtask

    task automatic test_abort;
        logic [127:0] last_key;
        start_read(0);
        drain(0, 4, last_key);
        rkey_vld = 1'b1;
        rkey     = sched[1][0];
        step;
        rkey_vld = 1'b0;
        exp_q.delete();
        total_cnt += 3;
        if (rk_vld !== 1'b0)  $display("FAIL abort_rk_vld: got %b expected 0", rk_vld);   else pass_cnt++;
        if (ld_ok !== 1'b1)   $display("FAIL abort_ld_ok: got %b expected 1", ld_ok);     else pass_cnt++;
        if (st_full !== 1'b0) $display("FAIL abort_st_full: got %b expected 0", st_full); else pass_cnt++;
        load(1, 1, 15, 14, -1);
        total_cnt++;
        if (st_full !== 1'b1) $display("FAIL abort_ld_full: got %b expected 1", st_full); else pass_cnt++;
        start_read(1);
        drain(0, 15, last_key);
    endtask

    task automatic test_rst_mid;
        logic [127:0] last_key;
        start_read(1);
        drain(0, 3, last_key);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        total_cnt += 3;
        if (rk_vld !== 1'b0)  $display("FAIL arst_rk_vld: got %b expected 0", rk_vld);   else pass_cnt++;
        if (st_full !== 1'b0) $display("FAIL arst_st_full: got %b expected 0", st_full); else pass_cnt++;
        if (ld_ok !== 1'b1)   $display("FAIL arst_ld_ok: got %b expected 1", ld_ok);     else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        step;
        rd_start = 1'b1;
        step;
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (rk_vld !== 1'b0) $display("FAIL arst_rd_ignored%0d: got %b expected 0", i, rk_vld);
            else pass_cnt++;
            step;
        end
    endtask

    initial begin
        expand(0, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        expand(1, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        test_reset;
        test_load_basic;
        test_read_full;
        test_read_stall;
        test_load_vs_read;
        test_bad_load;
        test_abort;
        test_rst_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
